fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequencing and fetch datapath in front of the 8-phase instruction controller.
- Generates the 3-bit phase count that the controller decodes, and holds the instruction register that supplies opcode and operand address.
- Holds the program counter and the memory address mux.
- Consumes the controller strobes (sel, ld_ir, inc_pc, ld_pc, halt) and adds halt and single-step run control.

Parameters:
- AWIDTH, 5, address width of pc, operand address and memory address.
- DWIDTH, 8, data bus width; instruction = {opcode[DWIDTH-1:DWIDTH-3], operand address[AWIDTH-1:0]}.
- OPW, 3, opcode width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DWIDTH  memory data bus, sampled into the IR.
- sel  in  1  controller strobe: 1 = mem_addr shows pc, 0 = mem_addr shows ir_addr.
- ld_ir  in  1  controller strobe: load IR from data_in.
- inc_pc  in  1  controller strobe: pc <= pc+1.
- ld_pc  in  1  controller strobe: pc <= ir_addr.
- halt  in  1  controller strobe: enter HALTED.
- step_mode  in  1  1 = pause after every instruction.
- run  in  1  single-cycle resume pulse from HALTED or PAUSED.
- phase  out  3  current phase 0..7, fed to the controller.
- opcode  out  OPW  IR opcode field.
- ir_addr  out  AWIDTH  IR operand address field.
- pc  out  AWIDTH  program counter.
- mem_addr  out  AWIDTH  combinational: sel ? pc : ir_addr.
- halted  out  1  1 in HALTED state.
- paused  out  1  1 in PAUSED state.
- insn_done  out  1  1 during the phase-7 cycle that advances to phase 0.

Behaviour:
- Reset values: phase=0, pc=0, IR=0 (opcode=0, ir_addr=0), state=RUN, halted=0, paused=0, insn_done=0.
- rst overrides everything, in any state and at any phase.
- States: RUN, HALTED, PAUSED.
- RUN:
  - phase <= phase+1 every cycle, wrapping 7->0.
  - IR and pc follow the strobes.
- Edge in RUN with halt=1:
  - inc_pc/ld_pc/ld_ir on that edge still take effect.
  - state <= HALTED.
  - phase does NOT advance (stays at 4).
- HALTED:
  - phase, pc and IR are frozen.
  - All strobes are ignored; this suppresses the repeated phase-4 inc_pc.
  - halt=1 is ignored; run=1 -> state <= RUN and phase <= phase+1 (4->5) on the same edge.
  - After resume, phases 5..7 complete the HLT instruction with no effect; the next fetch uses the incremented pc.
- Edge in RUN with phase=7 and step_mode=1:
  - phase <= 0 and state <= PAUSED.
  - insn_done=1 during that phase-7 cycle as usual.
- PAUSED:
  - phase is held at 0; pc and IR are frozen; strobes are ignored.
  - run=1 -> state <= RUN, phase <= 1.
  - step_mode dropping while PAUSED does not resume; run is still required.
- pc update:
  - ld_pc has priority over inc_pc.
  - Arithmetic is modulo 2^AWIDTH: pc=2^AWIDTH-1 with inc_pc wraps to 0.
- IR: loads the full data_in whenever ld_ir=1 in RUN; loading on consecutive cycles is allowed, last value wins.
- run while in RUN is ignored; run coincident with rst is ignored.
- mem_addr tracks sel, pc and ir_addr with zero latency.
- Latency from ld_ir edge to opcode/ir_addr valid: 1 cycle.
- halted and paused are registered state decodes; they are never both 1.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7;
  - phase constants PH_FETCH0..PH_EXEC7 (0..7);
  - run-state encoding RUN/HALTED/PAUSED;
  - default widths AWIDTH/DWIDTH/OPW.
- Sub-module pc_counter: AWIDTH-bit register with synchronous reset, load (priority), increment, and an enable that the state machine drives low in HALTED/PAUSED.
- Phase counter, IR and state machine stay in fetch_sequencer.

Test Plan:
- Reset then free run:
  - rst=1 for 2 cycles, release, step_mode=0, strobes 0 -> phase 0,1,..7,0,1.
  - insn_done=1 only in phase-7 cycles; pc=0.
- Fetch and increment:
  - data_in=8'hA7, ld_ir=1 at phases 2-3, inc_pc=1 at phase 4 -> opcode=5, ir_addr=7, pc=1.
  - mem_addr=pc while sel=1, =7 while sel=0.
- Jump priority:
  - ir_addr=5'h1C, ld_pc=1 and inc_pc=1 on the same edge -> pc=5'h1C.
  - pc=5'h1F with inc_pc=1 -> pc=0.
- Halt and resume:
  - At phase 4, halt=1 and inc_pc=1 with pc=3 -> pc=4, halted=1, phase stuck at 4 for 10 cycles with strobes still active.
  - run pulse -> phase 5, halted=0, pc still 4.
- Single step:
  - step_mode=1 -> after phase 7, paused=1 and phase=0 held for 5 cycles.
  - run pulse -> phase 1 the next cycle.
- Reset mid-operation:
  - rst=1 at phase 6 with pc=9, and again while HALTED -> next cycle phase=0, pc=0, IR=0, halted=0, paused=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/sequencing datapath in front of the
// 8-phase instruction controller: opcode and phase encodings, the run-state
// encoding used by fetch_sequencer, and default bus widths.
package cpu_pkg;

    // Default widths
    localparam int AWIDTH = 5;
    localparam int DWIDTH = 8;
    localparam int OPW    = 3;

    typedef logic [2:0] phase_t;

    // Opcodes (upper OPW bits of the instruction word)
    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    // Phase numbers decoded by the controller
    localparam phase_t PH_FETCH0 = 3'd0;
    localparam phase_t PH_FETCH1 = 3'd1;
    localparam phase_t PH_FETCH2 = 3'd2;
    localparam phase_t PH_FETCH3 = 3'd3;
    localparam phase_t PH_EXEC4  = 3'd4;
    localparam phase_t PH_EXEC5  = 3'd5;
    localparam phase_t PH_EXEC6  = 3'd6;
    localparam phase_t PH_EXEC7  = 3'd7;

    // Run-state encoding
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] HALTED = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;

endpackage

// File: rtl/pc_counter.sv
// Program counter register.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : 0 freezes the counter (driven low while halted/paused)
//   load     : q <= d (wins over inc)
//   inc      : q <= q + 1, wrapping modulo 2^AWIDTH
//   d        : load value
//   q        : current program counter
module pc_counter #(
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              inc,
    input  logic [AWIDTH-1:0] d,
    output logic [AWIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            if (load)
                q <= d;
            else if (inc)
                q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Sequencing and fetch datapath for the 8-phase instruction controller.
// Generates the phase count, holds the instruction register and the program
// counter, muxes the memory address, and adds halt / single-step run control.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   data_in         : memory data bus, loaded into the IR on ld_ir
//   sel             : 1 = mem_addr shows pc, 0 = mem_addr shows ir_addr
//   ld_ir, inc_pc,
//   ld_pc, halt     : controller strobes (honoured only in RUN)
//   step_mode       : pause at the end of every instruction
//   run             : resume pulse from HALTED or PAUSED
//   phase           : current phase 0..7
//   opcode, ir_addr : IR fields
//   pc, mem_addr    : program counter, memory address (combinational mux)
//   halted, paused  : run-state decodes
//   insn_done       : high in the phase-7 cycle that wraps to phase 0
import cpu_pkg::*;

module fetch_sequencer #(
    parameter int AWIDTH = cpu_pkg::AWIDTH,
    parameter int DWIDTH = cpu_pkg::DWIDTH,
    parameter int OPW    = cpu_pkg::OPW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              sel,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              ld_pc,
    input  logic              halt,
    input  logic              step_mode,
    input  logic              run,
    output logic [2:0]        phase,
    output logic [OPW-1:0]    opcode,
    output logic [AWIDTH-1:0] ir_addr,
    output logic [AWIDTH-1:0] pc,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              halted,
    output logic              paused,
    output logic              insn_done
);

    logic [1:0]        state;
    logic [DWIDTH-1:0] ir;
    logic              active;

    // Strobes only matter while running; HALTED/PAUSED freeze pc and IR,
    // which also swallows the phase-4 inc_pc the controller keeps asserting
    // while a HLT sits in the IR.
    assign active = (state == RUN);

    pc_counter #(.AWIDTH(AWIDTH)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .en   (active),
        .load (ld_pc),
        .inc  (inc_pc),
        .d    (ir_addr),
        .q    (pc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            ir <= '0;
        else if (active && ld_ir)
            ir <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            phase <= PH_FETCH0;
        end else begin
            case (state)
                RUN: begin
                    // halt freezes the phase where it was raised so that
                    // resume continues with the rest of the HLT instruction.
                    if (halt) begin
                        state <= HALTED;
                    end else if (phase == PH_EXEC7 && step_mode) begin
                        state <= PAUSED;
                        phase <= PH_FETCH0;
                    end else begin
                        phase <= phase + 3'd1;
                    end
                end
                HALTED: begin
                    if (run) begin
                        state <= RUN;
                        phase <= phase + 3'd1;
                    end
                end
                PAUSED: begin
                    if (run) begin
                        state <= RUN;
                        phase <= PH_FETCH1;
                    end
                end
                default: begin
                    state <= RUN;
                    phase <= PH_FETCH0;
                end
            endcase
        end
    end

    assign opcode    = ir[DWIDTH-1 -: OPW];
    assign ir_addr   = ir[AWIDTH-1:0];
    assign mem_addr  = sel ? pc : ir_addr;
    assign halted    = (state == HALTED);
    assign paused    = (state == PAUSED);
    // A halt at phase 7 holds the phase, so that cycle does not finish
    // the instruction.
    assign insn_done = active && (phase == PH_EXEC7) && !halt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer. The driver sets inputs for a
// cycle and queues the outputs expected during that cycle; the monitor pops
// and compares at the falling edge.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst, sel, ld_ir, inc_pc, ld_pc, halt, step_mode, run;
    logic [7:0] data_in;
    logic [2:0] phase, opcode;
    logic [4:0] ir_addr, pc, mem_addr;
    logic       halted, paused, insn_done;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sel       (sel),
        .ld_ir     (ld_ir),
        .inc_pc    (inc_pc),
        .ld_pc     (ld_pc),
        .halt      (halt),
        .step_mode (step_mode),
        .run       (run),
        .phase     (phase),
        .opcode    (opcode),
        .ir_addr   (ir_addr),
        .pc        (pc),
        .mem_addr  (mem_addr),
        .halted    (halted),
        .paused    (paused),
        .insn_done (insn_done)
    );

    typedef struct {
        string      name;
        logic [2:0] phase;
        logic [4:0] pc;
        logic [2:0] opcode;
        logic [4:0] ir_addr;
        logic [4:0] mem_addr;
        logic       halted;
        logic       paused;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   errors = 0;

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if (phase !== e.phase || pc !== e.pc || opcode !== e.opcode ||
                ir_addr !== e.ir_addr || mem_addr !== e.mem_addr ||
                halted !== e.halted || paused !== e.paused || insn_done !== e.done) begin
                errors++;
                $display("FAIL %s: got ph=%0d pc=%h op=%0d ira=%h ma=%h h=%b p=%b d=%b, want ph=%0d pc=%h op=%0d ira=%h ma=%h h=%b p=%b d=%b",
                         e.name, phase, pc, opcode, ir_addr, mem_addr, halted, paused, insn_done,
                         e.phase, e.pc, e.opcode, e.ir_addr, e.mem_addr, e.halted, e.paused, e.done);
            end
        end
    end

    // Queue what the outputs should be during the current cycle, then advance.
    task automatic chk(input string nm, input int ph, input int pcv, input int opc,
                       input int ira, input bit h, input bit p, input bit d);
        exp_t e;
        e.name     = nm;
        e.phase    = 3'(ph);
        e.pc       = 5'(pcv);
        e.opcode   = 3'(opc);
        e.ir_addr  = 5'(ira);
        e.mem_addr = sel ? 5'(pcv) : 5'(ira);
        e.halted   = h;
        e.paused   = p;
        e.done     = d;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input bit ir_, input bit inc_, input bit ldpc_, input bit h_);
        ld_ir  = ir_;
        inc_pc = inc_;
        ld_pc  = ldpc_;
        halt   = h_;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; data_in = 8'h00; step_mode = 1'b0; run = 1'b0;
        strobes(0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("reset_a", 0, 0, 0, 0, 0, 0, 0);
        chk("reset_b", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Free run: phases 0..7,0,1 with insn_done only at phase 7
        for (int i = 0; i < 10; i++)
            chk("free_run", i % 8, 0, 0, 0, 0, 0, (i % 8) == 7);

        // Fetch A7 at phases 2-3, increment at phase 4
        sel = 1'b1; data_in = 8'hA7; strobes(1, 0, 0, 0);
        chk("fetch_p2", 2, 0, 0, 0, 0, 0, 0);
        chk("fetch_p3", 3, 0, 5, 7, 0, 0, 0);
        strobes(0, 1, 0, 0);
        chk("inc_p4", 4, 0, 5, 7, 0, 0, 0);
        strobes(0, 0, 0, 0); sel = 1'b0;
        chk("memaddr_ir", 5, 1, 5, 7, 0, 0, 0);
        sel = 1'b1;
        chk("memaddr_pc", 6, 1, 5, 7, 0, 0, 0);
        chk("done_p7", 7, 1, 5, 7, 0, 0, 1);

        // Jump priority and pc wrap
        data_in = 8'hFC; strobes(1, 0, 0, 0);
        chk("ld_jmp", 0, 1, 5, 7, 0, 0, 0);
        strobes(0, 1, 1, 0);
        chk("ldpc_prio", 1, 1, 7, 5'h1C, 0, 0, 0);
        strobes(0, 1, 0, 0);
        chk("inc_1c", 2, 5'h1C, 7, 5'h1C, 0, 0, 0);
        chk("inc_1d", 3, 5'h1D, 7, 5'h1C, 0, 0, 0);
        chk("inc_1e", 4, 5'h1E, 7, 5'h1C, 0, 0, 0);
        chk("inc_1f", 5, 5'h1F, 7, 5'h1C, 0, 0, 0);
        strobes(0, 0, 0, 0);
        chk("pc_wrap", 6, 0, 7, 5'h1C, 0, 0, 0);
        chk("wrap_p7", 7, 0, 7, 5'h1C, 0, 0, 1);

        // Halt at phase 4 with pc=3, strobes kept active while halted
        data_in = 8'h03; strobes(1, 0, 0, 0);
        chk("ld_hlt", 0, 0, 7, 5'h1C, 0, 0, 0);
        strobes(0, 0, 1, 0);
        chk("pc_to_3", 1, 0, 0, 3, 0, 0, 0);
        strobes(0, 0, 0, 0);
        chk("hlt_p2", 2, 3, 0, 3, 0, 0, 0);
        chk("hlt_p3", 3, 3, 0, 3, 0, 0, 0);
        strobes(0, 1, 0, 1);
        chk("halt_edge", 4, 3, 0, 3, 0, 0, 0);
        data_in = 8'hFF; strobes(1, 1, 1, 1);
        for (int i = 0; i < 10; i++)
            chk("halted_hold", 4, 4, 0, 3, 1, 0, 0);
        strobes(0, 0, 0, 0); run = 1'b1;
        chk("resume_edge", 4, 4, 0, 3, 1, 0, 0);
        run = 1'b0;
        chk("resumed_p5", 5, 4, 0, 3, 0, 0, 0);
        chk("resumed_p6", 6, 4, 0, 3, 0, 0, 0);
        chk("resumed_p7", 7, 4, 0, 3, 0, 0, 1);

        // Single step: pause after phase 7, strobes ignored, run -> phase 1
        step_mode = 1'b1;
        for (int i = 0; i < 7; i++)
            chk("step_run", i, 4, 0, 3, 0, 0, 0);
        chk("step_p7", 7, 4, 0, 3, 0, 0, 1);
        strobes(1, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) step_mode = 1'b0;
            chk("paused_hold", 0, 4, 0, 3, 0, 1, 0);
        end
        strobes(0, 0, 0, 0); run = 1'b1;
        chk("pause_resume", 0, 4, 0, 3, 0, 1, 0);
        chk("run_in_run", 1, 4, 0, 3, 0, 0, 0);
        run = 1'b0;

        // Reset at phase 6 with pc=9
        data_in = 8'h09; strobes(1, 0, 0, 0);
        chk("ld_09", 2, 4, 0, 3, 0, 0, 0);
        strobes(0, 0, 1, 0);
        chk("pc_to_9", 3, 4, 0, 9, 0, 0, 0);
        strobes(0, 0, 0, 0);
        chk("pre_rst_p4", 4, 9, 0, 9, 0, 0, 0);
        chk("pre_rst_p5", 5, 9, 0, 9, 0, 0, 0);
        rst = 1'b1;
        chk("rst_p6", 6, 9, 0, 9, 0, 0, 0);
        rst = 1'b0;
        chk("after_rst", 0, 0, 0, 0, 0, 0, 0);

        // Reset while HALTED, with a coincident run pulse
        chk("rh_p1", 1, 0, 0, 0, 0, 0, 0);
        chk("rh_p2", 2, 0, 0, 0, 0, 0, 0);
        chk("rh_p3", 3, 0, 0, 0, 0, 0, 0);
        strobes(0, 0, 0, 1);
        chk("rh_halt", 4, 0, 0, 0, 0, 0, 0);
        strobes(0, 0, 0, 0); rst = 1'b1; run = 1'b1;
        chk("rst_halted", 4, 0, 0, 0, 1, 0, 0);
        rst = 1'b0; run = 1'b0;
        chk("after_rst_h", 0, 0, 0, 0, 0, 0, 0);
        chk("after_rst_p1", 1, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
